data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 65 ++++++
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state type,
// default geometry and the width of the incoming request address.
// Optional feature macro: DMEM_PARITY_EN (per-word even parity).
package dmem_pkg;

    // Width of the request address bus, independent of the decoded array size
    localparam int REQ_ADDR_W      = 16;

    // Default geometry of the backing array
    localparam int DMEM_ADDR_W_DEF = 8;
    localparam int DMEM_DATA_W_DEF = 16;

    // Wait-state counter width; covers WAIT_CYC up to 15
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM behind the responder. One access per enable:
// a store writes the word, a load registers the word into rdata_o, which
// then holds until the next load.
// With DMEM_PARITY_EN each word carries an extra even-parity bit that is
// checked on loads and reported through par_err_o.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W_DEF,
    parameter int DATA_W = DMEM_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              par_err_o
);

    localparam int DEPTH = 1 << ADDR_W;
`ifdef DMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  mem_q [DEPTH];
    logic [MEM_W-1:0]  wword;
    logic [DATA_W-1:0] rdata_q;

`ifdef DMEM_PARITY_EN
    logic par_err_q;
    // Parity bit in the MSB makes the XOR of the whole stored word zero
    assign wword = {^wdata_i, wdata_i};
`else
    assign wword = wdata_i;
`endif

    // Store writes the word; load registers the addressed word (no reset: RAM)
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wword;
            end else begin
                rdata_q <= mem_q[addr_i][DATA_W-1:0];
            end
        end
    end

`ifdef DMEM_PARITY_EN
    // Parity check registered alongside the load data; stores clear it
    always_ff @(posedge clk) begin
        if (en_i) begin
            par_err_q <= we_i ? 1'b0 : (^mem_q[addr_i]);
        end
    end
    assign par_err_o = par_err_q;
`else
    assign par_err_o = 1'b0;
`endif

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the Memory Access stage. Accepts one request at
// a time in IDLE, waits WAIT_CYC wait states, performs the array access on
// the transition into RESP and holds the response until it is consumed.
// Addresses with bits set above ADDR_W are rejected with resp_err and never
// touch the array. Optional feature macro: DMEM_PARITY_EN (parity errors
// also raise resp_err on loads).
// resetn is active-high and synchronous; outputs are forced to 0 while it
// is asserted.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W_DEF,
    parameter int DATA_W   = DMEM_DATA_W_DEF,
    parameter int WAIT_CYC = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [REQ_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    // Counter preload; with no wait states IDLE jumps straight to RESP
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((WAIT_CYC == 0) ? 0 : (WAIT_CYC - 1));

    dmem_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q;
    logic [REQ_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;

    logic                  accept;
    logic                  into_resp;
    logic                  cur_we;
    logic [REQ_ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0]     cur_wdata;
    logic                  cur_oor;
    logic                  oor_q;
    logic                  arr_en;
    logic [DATA_W-1:0]     arr_rdata;
    logic                  arr_par_err;

    assign accept = req_valid && req_ready;

    // In IDLE the access may happen on the accepting edge itself (no wait
    // states), so the array sees the live request there and the captured
    // one everywhere else.
    assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign cur_oor   = (cur_addr >> ADDR_W) != '0;
    assign oor_q     = (addr_q >> ADDR_W) != '0;

    // A reset edge must never commit a store, even when it lands on the
    // cycle that would have entered RESP.
    assign arr_en = into_resp && !cur_oor && !resetn;

    // State and wait counter
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture on acceptance; held stable through WAIT and RESP
    always_ff @(posedge clk) begin
        if (resetn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Next-state, counter and array-access strobe
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        into_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYC == 0) begin
                        state_d   = RESP;
                        into_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    into_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk       (clk),
        .en_i      (arr_en),
        .we_i      (cur_we),
        .addr_i    (cur_addr[ADDR_W-1:0]),
        .wdata_i   (cur_wdata),
        .rdata_o   (arr_rdata),
        .par_err_o (arr_par_err)
    );

    // Response outputs are decoded from held state, so they stay stable
    // for as long as RESP is held by backpressure.
    assign req_ready  = (state_q == IDLE) && !resetn;
    assign resp_valid = (state_q == RESP) && !resetn;
    assign resp_err   = resp_valid && (oor_q || (!we_q && arr_par_err));
    assign resp_rdata = (resp_valid && !we_q && !oor_q) ? arr_rdata : '0;

endmodule
